// File: rtl/a5_burst_engine.sv
// a5_burst_engine: self-sequencing A5/1-style keystream engine for one GSM frame.
//
// Loads a session key and frame number into three majority-clocked LFSRs and runs
// the warm-up. It then generates NCHUNKS bursts of CHUNKLEN keystream bits and
// XORs each burst with the payload that was latched at start.
//
// Optional build macro: A5_KEYSTREAM_TAP_EN adds the ks_bit/ks_valid debug tap.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      frame request, accepted only when idle
//   abort      synchronous cancel, overrides everything
//   key        session key, key[0] loaded first
//   frame      frame number, frame[0] loaded first
//   in_data    payload, chunk c at [c*CHUNKLEN +: CHUNKLEN]
//   busy       high whenever the engine is not idle
//   out_valid  one-cycle pulse per completed chunk
//   out_index  chunk number held in out_data
//   out_data   ciphered chunk
//   done       one-cycle pulse together with the last out_valid
//   ks_bit     (tap build only) raw keystream bit of the current GEN cycle
//   ks_valid   (tap build only) high in every GEN cycle
module a5_burst_engine #(
  parameter int                 REG1LEN  = 19,
  parameter int                 REG2LEN  = 22,
  parameter int                 REG3LEN  = 23,
  parameter logic [REG1LEN-1:0] MASK1    = 19'h72000,
  parameter logic [REG2LEN-1:0] MASK2    = 22'h300000,
  parameter logic [REG3LEN-1:0] MASK3    = 23'h700080,
  parameter int                 SYNCBIT1 = 8,
  parameter int                 SYNCBIT2 = 10,
  parameter int                 SYNCBIT3 = 10,
  parameter int                 KEYLEN   = 64,
  parameter int                 FRAMELEN = 22,
  parameter int                 WARMUP   = 100,
  parameter int                 CHUNKLEN = 114,
  parameter int                 NCHUNKS  = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [KEYLEN-1:0]           key,
  input  logic [FRAMELEN-1:0]         frame,
  input  logic [NCHUNKS*CHUNKLEN-1:0] in_data,
  output logic                        busy,
  output logic                        out_valid,
  output logic [$clog2(NCHUNKS):0]    out_index,
  output logic [CHUNKLEN-1:0]         out_data,
  output logic                        done
`ifdef A5_KEYSTREAM_TAP_EN
  ,
  output logic                        ks_bit,
  output logic                        ks_valid
`endif
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  localparam int IW      = $clog2(NCHUNKS) + 1;
  localparam int DW      = NCHUNKS * CHUNKLEN;
  localparam int CNT_MAX = imax(imax(KEYLEN, FRAMELEN), imax(WARMUP, CHUNKLEN));
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LOAD_KEY   = 3'd1;
  localparam logic [2:0] ST_LOAD_FRAME = 3'd2;
  localparam logic [2:0] ST_WARMUP     = 3'd3;
  localparam logic [2:0] ST_GEN        = 3'd4;

  generate
    if (SYNCBIT1 >= REG1LEN || !MASK1[REG1LEN-1]) begin : g_bad_lfsr1
      $error("a5_burst_engine: LFSR 1 clocking bit out of range or mask MSB clear");
    end
    if (SYNCBIT2 >= REG2LEN || !MASK2[REG2LEN-1]) begin : g_bad_lfsr2
      $error("a5_burst_engine: LFSR 2 clocking bit out of range or mask MSB clear");
    end
    if (SYNCBIT3 >= REG3LEN || !MASK3[REG3LEN-1]) begin : g_bad_lfsr3
      $error("a5_burst_engine: LFSR 3 clocking bit out of range or mask MSB clear");
    end
  endgenerate

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       chunk;
  logic [REG1LEN-1:0]  r1, r1_nxt;
  logic [REG2LEN-1:0]  r2, r2_nxt;
  logic [REG3LEN-1:0]  r3, r3_nxt;
  logic [KEYLEN-1:0]   key_lat;
  logic [FRAMELEN-1:0] frame_lat;
  logic [DW-1:0]       data_lat;
  logic                loading, maj, inj_bit, en1, en2, en3, ks, data_bit;
  logic                last_bit, last_chunk;

  assign busy    = (state != ST_IDLE);
  assign loading = (state == ST_LOAD_KEY) || (state == ST_LOAD_FRAME);
  assign maj     = maj3(r1[SYNCBIT1], r2[SYNCBIT2], r3[SYNCBIT3]);

  // Bit selects use a one-hot mask so the shared counter width never has to
  // match the index width of the vector being read.
  assign inj_bit = (state == ST_LOAD_KEY)   ? |(key_lat & (KEYLEN'(1) << cnt)) :
                   (state == ST_LOAD_FRAME) ? |(frame_lat & (FRAMELEN'(1) << cnt)) :
                   1'b0;

  // During loading every register steps; otherwise only those agreeing with the majority.
  assign en1 = loading | (r1[SYNCBIT1] == maj);
  assign en2 = loading | (r2[SYNCBIT2] == maj);
  assign en3 = loading | (r3[SYNCBIT3] == maj);

  assign r1_nxt = en1 ? {r1[REG1LEN-2:0], (^(r1 & MASK1)) ^ inj_bit} : r1;
  assign r2_nxt = en2 ? {r2[REG2LEN-2:0], (^(r2 & MASK2)) ^ inj_bit} : r2;
  assign r3_nxt = en3 ? {r3[REG3LEN-2:0], (^(r3 & MASK3)) ^ inj_bit} : r3;

  // Keystream is taken from the registers after this cycle's step.
  assign ks       = r1_nxt[REG1LEN-1] ^ r2_nxt[REG2LEN-1] ^ r3_nxt[REG3LEN-1];
  assign data_bit = ks ^ |(data_lat & (DW'(1) << (int'(chunk) * CHUNKLEN + int'(cnt))));

  assign last_bit   = (cnt == CW'(CHUNKLEN - 1));
  assign last_chunk = (chunk == IW'(NCHUNKS - 1));

  // Control and keystream state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      chunk     <= '0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      chunk     <= '0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            cnt   <= '0;
            chunk <= '0;
            state <= ST_LOAD_KEY;
          end
        end
        ST_LOAD_KEY: begin
          r1 <= r1_nxt;
          r2 <= r2_nxt;
          r3 <= r3_nxt;
          if (cnt == CW'(KEYLEN - 1)) begin
            cnt   <= '0;
            state <= ST_LOAD_FRAME;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOAD_FRAME: begin
          r1 <= r1_nxt;
          r2 <= r2_nxt;
          r3 <= r3_nxt;
          if (cnt == CW'(FRAMELEN - 1)) begin
            cnt   <= '0;
            state <= ST_WARMUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WARMUP: begin
          r1 <= r1_nxt;
          r2 <= r2_nxt;
          r3 <= r3_nxt;
          if (cnt == CW'(WARMUP - 1)) begin
            cnt   <= '0;
            state <= ST_GEN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GEN: begin
          r1       <= r1_nxt;
          r2       <= r2_nxt;
          r3       <= r3_nxt;
          out_data <= (out_data & ~(CHUNKLEN'(1) << cnt)) |
                      (data_bit ? (CHUNKLEN'(1) << cnt) : '0);
          if (last_bit) begin
            out_valid <= 1'b1;
            out_index <= chunk;
            cnt       <= '0;
            if (last_chunk) begin
              done  <= 1'b1;
              chunk <= '0;
              state <= ST_IDLE;
            end else begin
              chunk <= chunk + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request operands, captured once per accepted start
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && start && !abort) begin
      key_lat   <= key;
      frame_lat <= frame;
      data_lat  <= in_data;
    end
  end

`ifdef A5_KEYSTREAM_TAP_EN
  assign ks_bit   = ks;
  assign ks_valid = (state == ST_GEN);
`else
  // keystream stays internal when the tap ports are not built
`endif

endmodule

// File: tb/tb_a5_burst_engine.sv
module tb_a5_burst_engine;

  localparam int CL  = 114;
  localparam int NC  = 2;
  localparam int LAT = 301;

  localparam int unsigned TAPS [3] = '{32'h72000, 32'h300000, 32'h700080};
  localparam int          LENS [3] = '{19, 22, 23};
  localparam int          SYNC [3] = '{8, 10, 10};

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic         abort;
  logic [63:0]  key;
  logic [21:0]  frame;
  logic [227:0] in_data;
  logic         busy;
  logic         out_valid;
  logic [1:0]   out_index;
  logic [113:0] out_data;
  logic         done;

  a5_burst_engine dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .key       (key),
    .frame     (frame),
    .in_data   (in_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_data  (out_data),
    .done      (done)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [227:0] act, input logic [227:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: classic A5/1 written with integer shifts and a vote count.
  function automatic int unsigned shift_in(input int unsigned r, input int j, input bit b);
    bit p;
    p = ^(r & TAPS[j]);
    return ((r << 1) | 32'(p ^ b)) & ((32'd1 << LENS[j]) - 32'd1);
  endfunction

  function automatic logic [227:0] ref_ks(input logic [63:0] k, input logic [21:0] f);
    int unsigned r [3];
    logic [227:0] ks;
    int votes;
    bit m, b;
    ks = '0;
    r  = '{0, 0, 0};
    for (int i = 0; i < 86; i++) begin
      if (i < 64) b = k[i];
      else        b = f[i-64];
      for (int j = 0; j < 3; j++) r[j] = shift_in(r[j], j, b);
    end
    for (int i = 0; i < 328; i++) begin
      votes = 0;
      for (int j = 0; j < 3; j++) votes += int'((r[j] >> SYNC[j]) & 32'd1);
      m = (votes >= 2);
      for (int j = 0; j < 3; j++)
        if (bit'((r[j] >> SYNC[j]) & 32'd1) == m) r[j] = shift_in(r[j], j, 1'b0);
      if (i >= 100) ks[i-100] = bit'(((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)) & 32'd1);
    end
    return ks;
  endfunction

  // MSB-first byte string (15 bytes) to chunk bits: chunk bit b is string bit 119-b.
  function automatic logic [113:0] unpack120(input logic [119:0] v);
    logic [113:0] c;
    for (int b = 0; b < 114; b++) c[b] = v[119-b];
    return c;
  endfunction

  typedef struct {
    logic [63:0]  k;
    logic [21:0]  f;
    logic [227:0] d;
    logic [227:0] exp;
  } vec_t;

  vec_t         vecs [5];
  logic [227:0] conf_exp;
  logic [63:0]  conf_key;
  logic [21:0]  conf_frame;

  task automatic run_frame(input string tag, input logic [63:0] k, input logic [21:0] f,
                           input logic [227:0] d, input logic [227:0] exp, input int inj_cyc);
    int cyc;
    int nseen;
    logic [227:0] got;
    got = '0;
    @(negedge clock);
    key = k; frame = f; in_data = d; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    chk_i({tag, " busy after start"}, int'(busy), 1);
    nseen = 0;
    while (nseen < NC && cyc < LAT + NC * CL + 50) begin
      if (cyc == inj_cyc) begin
        start = 1'b1; key = ~k; frame = ~f; in_data = ~d;
      end else if (cyc == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (out_valid) begin
        chk_i({tag, " out_index"}, int'(out_index), nseen);
        chk_i({tag, " valid cycle"}, cyc, LAT + nseen * CL);
        chk_i({tag, " done"}, int'(done), (nseen == NC - 1) ? 1 : 0);
        got[nseen*CL +: CL] = out_data;
        nseen++;
      end
      @(negedge clock);
      cyc++;
    end
    chk_i({tag, " chunks seen"}, nseen, NC);
    chk_i({tag, " busy after done"}, int'(busy), 0);
    chk_i({tag, " valid after done"}, int'(out_valid), 0);
    chk_v({tag, " data"}, got, exp);
  endtask

  initial begin
    int cyc;
    int pulses;
    int nv;
    int ndone;
    int vc [4];
    logic [227:0] got2;
    logic [113:0] saved;
    logic [255:0] t;

    reset_n = 1'b1; start = 1'b0; abort = 1'b0;
    key = '0; frame = '0; in_data = '0;
    conf_key   = 64'hEFCDAB8967452312;
    conf_frame = 22'h134;
    conf_exp   = {unpack120(120'h24FD35A35D5FB6526D32F906DF1AC0),
                  unpack120(120'h534EAA582FE8151AB6E1855A728C00)};

    vecs[0] = '{k: conf_key, f: conf_frame, d: '0, exp: conf_exp};
    vecs[1] = '{k: conf_key, f: conf_frame, d: conf_exp, exp: '0};
    for (int v = 2; v < 5; v++) begin
      for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
      vecs[v].k = {$urandom, $urandom};
      vecs[v].f = 22'($urandom);
      vecs[v].d = (v == 2) ? '0 : t[227:0];
      vecs[v].exp = vecs[v].d ^ ref_ks(vecs[v].k, vecs[v].f);
    end

    // reset state
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_i("reset busy", int'(busy), 0);
    chk_i("reset out_valid", int'(out_valid), 0);
    chk_i("reset done", int'(done), 0);
    chk_i("reset out_index", int'(out_index), 0);
    chk_v("reset out_data", 228'(out_data), '0);
    reset_n = 1'b1;
    @(negedge clock);

    // table-driven frames
    for (int v = 0; v < 5; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].k, vecs[v].f, vecs[v].d, vecs[v].exp, -1);

    // start with a different key during warm-up is ignored
    run_frame("start in warmup", conf_key, conf_frame, '0, conf_exp, 120);

    // start and abort together in idle: stays idle
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk_i("start+abort idle busy", int'(busy), 0);

    // abort at cycle 150
    saved = out_data;
    @(negedge clock);
    key = conf_key; frame = conf_frame; in_data = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (cyc < 150) begin
      @(negedge clock);
      cyc++;
    end
    chk_i("busy before abort", int'(busy), 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk_i("busy after abort", int'(busy), 0);
    pulses = 0;
    for (int i = 0; i < 350; i++) begin
      if (out_valid || done || busy) pulses++;
      @(negedge clock);
    end
    chk_i("activity after abort", pulses, 0);
    chk_v("out_data kept on abort", 228'(out_data), 228'(saved));
    run_frame("after abort", conf_key, conf_frame, '0, conf_exp, -1);

    // asynchronous reset mid-GEN
    @(negedge clock);
    key = conf_key; frame = conf_frame; in_data = {228{1'b1}}; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 1; i < 350; i++) @(negedge clock);
    chk_i("busy mid-gen", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk_i("async reset busy", int'(busy), 0);
    chk_i("async reset out_valid", int'(out_valid), 0);
    chk_i("async reset done", int'(done), 0);
    chk_i("async reset out_index", int'(out_index), 0);
    chk_v("async reset out_data", 228'(out_data), '0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk_i("idle after reset release", int'(busy), 0);

    // back-to-back with start held high
    @(negedge clock);
    key = conf_key; frame = conf_frame; in_data = '0; start = 1'b1;
    @(negedge clock);
    cyc = 1; nv = 0; ndone = 0; got2 = '0;
    vc = '{0, 0, 0, 0};
    while (cyc < 900) begin
      if (cyc == 420) start = 1'b0;
      if (cyc == 416) chk_i("b2b busy after done", int'(busy), 1);
      if (out_valid) begin
        if (nv < 4) vc[nv] = cyc;
        if (nv >= 2 && nv < 4) got2[(nv-2)*CL +: CL] = out_data;
        nv++;
      end
      if (done) ndone++;
      @(negedge clock);
      cyc++;
    end
    chk_i("b2b valid count", nv, 4);
    chk_i("b2b valid0 cycle", vc[0], LAT);
    chk_i("b2b valid1 cycle", vc[1], LAT + CL);
    chk_i("b2b valid2 cycle", vc[2], LAT + CL + LAT);
    chk_i("b2b valid3 cycle", vc[3], LAT + CL + LAT + CL);
    chk_i("b2b done count", ndone, 2);
    chk_v("b2b second frame data", got2, conf_exp);
    chk_i("b2b busy at end", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
